// File: rtl/mem_stage_mc_if.sv
// Data-memory request/acknowledge bus between the MEM stage and a
// variable-latency data memory.
//   master : MEM stage (drives request, write enable, address, data, byte enables)
//   slave  : memory     (drives ack and read data)
// Signal summary:
//   mem_req_o   request outstanding
//   mem_we_o    write request
//   mem_addr_o  XLEN/8-aligned address
//   mem_wdata_o lane-replicated write data
//   mem_be_o    byte enables
//   mem_ack_i   access complete
//   mem_rdata_i read data, valid with ack
interface mem_stage_mc_if #(
  parameter int unsigned XLEN = 32
) ();
  logic                mem_req_o;
  logic                mem_we_o;
  logic [XLEN-1:0]     mem_addr_o;
  logic [XLEN-1:0]     mem_wdata_o;
  logic [XLEN/8-1:0]   mem_be_o;
  logic                mem_ack_i;
  logic [XLEN-1:0]     mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_stage_mc.sv
// MEM pipeline stage with a variable-latency req/ack data-memory port.
// Byte/half/word (and dword when XLEN=64) loads and stores, sign/zero
// extension, byte enables, upstream stall while an access is outstanding,
// and an internal MEM/WB output register.
// Optional feature: define MEM_TIMEOUT_EN to enable the ack watchdog
// (TIMEOUT_CYCLES BUSY cycles without ack -> bus_err_o pulse).
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   valid_i .. rd_i         instruction fields from EX/MEM
//   mem                     data-memory bus (mem_stage_mc_if.master)
//   stall_o                 combinational upstream hold
//   valid_o .. rd_o         registered MEM/WB fields
//   misalign_o, bus_err_o   registered one-cycle fault flags
module mem_stage_mc #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_AW         = 5,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [XLEN-1:0]   ALUout_i,
  input  logic [XLEN-1:0]   regOp2_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [1:0]        MemSize_i,
  input  logic              MemUnsigned_i,
  input  logic              RegWrite_i,
  input  logic [1:0]        WriteSrc_i,
  input  logic [XLEN-1:0]   pcPlus4_i,
  input  logic [XLEN-1:0]   ImmOp_i,
  input  logic [REG_AW-1:0] rd_i,
  mem_stage_mc_if.master    mem,
  output logic              stall_o,
  output logic              valid_o,
  output logic              RegWrite_o,
  output logic [1:0]        WriteSrc_o,
  output logic [XLEN-1:0]   ALUout_o,
  output logic [XLEN-1:0]   DataMemOut_o,
  output logic [XLEN-1:0]   pcPlus4_o,
  output logic [XLEN-1:0]   ImmOp_o,
  output logic [REG_AW-1:0] rd_o,
  output logic              misalign_o,
  output logic              bus_err_o
);

  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned OFF_W = (XLEN == 64) ? 3 : 2;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0] state, state_d;

  // Fields captured on accept, consumed when the access completes
  logic [OFF_W-1:0]  lat_off, lat_off_d;
  logic [1:0]        lat_size, lat_size_d;
  logic              lat_uns, lat_uns_d;
  logic              lat_rw, lat_rw_d;
  logic [1:0]        lat_ws, lat_ws_d;
  logic [XLEN-1:0]   lat_alu, lat_alu_d;
  logic [XLEN-1:0]   lat_pc4, lat_pc4_d;
  logic [XLEN-1:0]   lat_imm, lat_imm_d;
  logic [REG_AW-1:0] lat_rd, lat_rd_d;

  // Next values of bus and MEM/WB registers
  logic              req_d, we_d;
  logic [XLEN-1:0]   addr_d, wdata_d;
  logic [BE_W-1:0]   be_d;
  logic              valid_d, rw_d, mis_d, berr_d;
  logic [1:0]        ws_d;
  logic [XLEN-1:0]   alu_d, dmo_d, pc4_d, imm_d;
  logic [REG_AW-1:0] rd_d;

  // Request decode from the incoming instruction
  logic [OFF_W-1:0]  off;
  logic              is_mem, aligned;
  logic [BE_W-1:0]   be_c;
  logic [XLEN-1:0]   wdata_c;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d;
`else
  logic [31:0] unused_tmo_cfg;
  assign unused_tmo_cfg = 32'(TIMEOUT_CYCLES);
`endif

  // Alignment, byte enables and lane-replicated store data
  always_comb begin
    off    = ALUout_i[OFF_W-1:0];
    is_mem = MemRead_i | MemWrite_i;
    case (MemSize_i)
      2'b00: begin
        aligned = 1'b1;
        be_c    = BE_W'(1) << off;
        wdata_c = {(XLEN/8){regOp2_i[7:0]}};
      end
      2'b01: begin
        aligned = ~off[0];
        be_c    = BE_W'(3) << off;
        wdata_c = {(XLEN/16){regOp2_i[15:0]}};
      end
      2'b10: begin
        aligned = (off[1:0] == 2'b00);
        be_c    = BE_W'(15) << off;
        wdata_c = {(XLEN/32){regOp2_i[31:0]}};
      end
      default: begin
        // dword exists only on a 64-bit datapath
        aligned = (XLEN == 64) && (off == '0);
        be_c    = '1;
        wdata_c = regOp2_i;
      end
    endcase
  end

  // Load formatting: move the addressed lane to bit 0, then push it to the
  // top and shift back down so sign/zero extension is one shift either way
  logic [XLEN-1:0]        lane, lane_up, zext;
  logic signed [XLEN-1:0] sext;
  logic [6:0]             ext_sh;
  logic [XLEN-1:0]        load_fmt;

  always_comb begin
    case (lat_size)
      2'b00:   ext_sh = 7'(XLEN - 8);
      2'b01:   ext_sh = 7'(XLEN - 16);
      2'b10:   ext_sh = 7'(XLEN - 32);
      default: ext_sh = 7'd0;
    endcase
    lane     = mem.mem_rdata_i >> {lat_off, 3'b000};
    lane_up  = lane << ext_sh;
    zext     = lane_up >> ext_sh;
    sext     = $signed(lane_up) >>> ext_sh;
    load_fmt = lat_uns ? zext : sext;
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next state, stall and next values of all registered outputs
  always_comb begin
    state_d    = state;
    stall_o    = 1'b0;
    req_d      = mem.mem_req_o;
    we_d       = mem.mem_we_o;
    addr_d     = mem.mem_addr_o;
    wdata_d    = mem.mem_wdata_o;
    be_d       = mem.mem_be_o;
    lat_off_d  = lat_off;
    lat_size_d = lat_size;
    lat_uns_d  = lat_uns;
    lat_rw_d   = lat_rw;
    lat_ws_d   = lat_ws;
    lat_alu_d  = lat_alu;
    lat_pc4_d  = lat_pc4;
    lat_imm_d  = lat_imm;
    lat_rd_d   = lat_rd;
    valid_d    = 1'b0;
    rw_d       = 1'b0;
    mis_d      = 1'b0;
    berr_d     = 1'b0;
    ws_d       = WriteSrc_o;
    alu_d      = ALUout_o;
    dmo_d      = DataMemOut_o;
    pc4_d      = pcPlus4_o;
    imm_d      = ImmOp_o;
    rd_d       = rd_o;
`ifdef MEM_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (valid_i) begin
          if (is_mem && aligned) begin
            stall_o    = 1'b1;
            state_d    = S_BUSY;
            req_d      = 1'b1;
            we_d       = MemWrite_i;
            addr_d     = {ALUout_i[XLEN-1:OFF_W], OFF_W'(0)};
            wdata_d    = wdata_c;
            be_d       = be_c;
            lat_off_d  = off;
            lat_size_d = MemSize_i;
            lat_uns_d  = MemUnsigned_i;
            lat_rw_d   = RegWrite_i;
            lat_ws_d   = WriteSrc_i;
            lat_alu_d  = ALUout_i;
            lat_pc4_d  = pcPlus4_i;
            lat_imm_d  = ImmOp_i;
            lat_rd_d   = rd_i;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_d  = '0;
`endif
          end else begin
            // Plain op or misaligned access: single-cycle pass-through
            valid_d = 1'b1;
            rw_d    = RegWrite_i & ~is_mem;
            mis_d   = is_mem;
            ws_d    = WriteSrc_i;
            alu_d   = ALUout_i;
            dmo_d   = '0;
            pc4_d   = pcPlus4_i;
            imm_d   = ImmOp_i;
            rd_d    = rd_i;
          end
        end
      end
      S_BUSY: begin
        stall_o = ~mem.mem_ack_i;
        if (mem.mem_ack_i) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          valid_d = 1'b1;
          rw_d    = lat_rw;
          ws_d    = lat_ws;
          alu_d   = lat_alu;
          dmo_d   = mem.mem_we_o ? '0 : load_fmt;
          pc4_d   = lat_pc4;
          imm_d   = lat_imm;
          rd_d    = lat_rd;
        end
`ifdef MEM_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          // Give up: release upstream and retire the op as a bus error
          stall_o = 1'b0;
          state_d = S_IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          valid_d = 1'b1;
          berr_d  = 1'b1;
          ws_d    = lat_ws;
          alu_d   = lat_alu;
          dmo_d   = '0;
          pc4_d   = lat_pc4;
          imm_d   = lat_imm;
          rd_d    = lat_rd;
        end else begin
          tmo_cnt_d = tmo_cnt + TMO_W'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus, latch and MEM/WB registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem.mem_req_o   <= 1'b0;
      mem.mem_we_o    <= 1'b0;
      mem.mem_addr_o  <= '0;
      mem.mem_wdata_o <= '0;
      mem.mem_be_o    <= '0;
      lat_off         <= '0;
      lat_size        <= '0;
      lat_uns         <= 1'b0;
      lat_rw          <= 1'b0;
      lat_ws          <= '0;
      lat_alu         <= '0;
      lat_pc4         <= '0;
      lat_imm         <= '0;
      lat_rd          <= '0;
      valid_o         <= 1'b0;
      RegWrite_o      <= 1'b0;
      misalign_o      <= 1'b0;
      bus_err_o       <= 1'b0;
      WriteSrc_o      <= '0;
      ALUout_o        <= '0;
      DataMemOut_o    <= '0;
      pcPlus4_o       <= '0;
      ImmOp_o         <= '0;
      rd_o            <= '0;
    end else begin
      mem.mem_req_o   <= req_d;
      mem.mem_we_o    <= we_d;
      mem.mem_addr_o  <= addr_d;
      mem.mem_wdata_o <= wdata_d;
      mem.mem_be_o    <= be_d;
      lat_off         <= lat_off_d;
      lat_size        <= lat_size_d;
      lat_uns         <= lat_uns_d;
      lat_rw          <= lat_rw_d;
      lat_ws          <= lat_ws_d;
      lat_alu         <= lat_alu_d;
      lat_pc4         <= lat_pc4_d;
      lat_imm         <= lat_imm_d;
      lat_rd          <= lat_rd_d;
      valid_o         <= valid_d;
      RegWrite_o      <= rw_d;
      misalign_o      <= mis_d;
      bus_err_o       <= berr_d;
      WriteSrc_o      <= ws_d;
      ALUout_o        <= alu_d;
      DataMemOut_o    <= dmo_d;
      pcPlus4_o       <= pc4_d;
      ImmOp_o         <= imm_d;
      rd_o            <= rd_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Ack watchdog counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tmo_cnt <= '0;
    else       tmo_cnt <= tmo_cnt_d;
  end
`endif

endmodule

// File: doc/mem_stage_mc.md
Name: mem_stage_mc

Overview:
- Parametrised successor MEM pipeline stage for the RV core.
- Talks to a variable-latency data memory over a req/ack port, which replaces the fixed single-cycle byte RAM.
- Supports byte/half/word loads and stores (doubleword when XLEN=64), with sign or zero extension and byte enables.
- Raises stall_o upstream while an access is outstanding, and registers results into an internal MEM/WB register.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- REG_AW, 5, register-index width.
- TIMEOUT_CYCLES, 64, ack watchdog limit; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- valid_i  in  1  instruction present in MEM.
- ALUout_i  in  XLEN  effective address / ALU result.
- regOp2_i  in  XLEN  store data.
- MemRead_i  in  1  load.
- MemWrite_i  in  1  store.
- MemSize_i  in  2  access size: 00 byte, 01 half, 10 word, 11 dword.
- MemUnsigned_i  in  1  zero-extend loads when 1.
- RegWrite_i  in  1  passthrough.
- WriteSrc_i  in  2  passthrough.
- pcPlus4_i  in  XLEN  passthrough.
- ImmOp_i  in  XLEN  passthrough.
- rd_i  in  REG_AW  passthrough.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  write request.
- mem_addr_o  out  XLEN  address, aligned to XLEN/8.
- mem_wdata_o  out  XLEN  write data, lane-replicated.
- mem_be_o  out  XLEN/8  byte enables.
- mem_ack_i  in  1  access complete.
- mem_rdata_i  in  XLEN  read data, valid with ack.
- stall_o  out  1  hold upstream stages.
- valid_o, RegWrite_o, WriteSrc_o, ALUout_o, DataMemOut_o, pcPlus4_o, ImmOp_o, rd_o  out  —  registered MEM/WB outputs.
- misalign_o  out  1  registered misaligned-access flag.
- bus_err_o  out  1  registered timeout flag.

Behaviour:
- Reset (asynchronous, immediate):
  - FSM returns to IDLE.
  - mem_req_o, mem_we_o and stall_o go to 0.
  - Every registered output goes to 0.
- FSM states: IDLE, BUSY.
- IDLE, no memory op (valid_i & !(MemRead_i|MemWrite_i)):
  - Passthrough fields are registered next edge; valid_o=1, DataMemOut_o=0.
  - Latency 1, stall_o=0.
- IDLE, valid_i=0: registers bubble next edge (valid_o=0, RegWrite_o=0).
- IDLE, aligned memory op:
  - stall_o=1 combinationally.
  - Address, size, unsigned flag, write data and passthrough fields are latched.
  - FSM moves to BUSY; valid_o=0 next edge.
- BUSY:
  - mem_req_o=1; mem_addr_o, mem_we_o, mem_wdata_o and mem_be_o are held stable.
  - stall_o = !mem_ack_i.
  - On ack: the load result is formatted and registered together with the latched fields, valid_o=1, and the FSM returns to IDLE.
  - Minimum memory-op latency is 2 cycles (accept cycle + BUSY cycle with ack).
- mem_ack_i in IDLE is ignored.
- Inputs presented during BUSY are ignored, since upstream is stalled.
- Alignment: off = ALUout_i[log2(XLEN/8)-1:0].
  - Misaligned cases: half with off[0]=1; word with off[1:0]≠0; dword with off≠0.
  - Size 11 when XLEN=32 is treated as misaligned.
  - Misaligned access: no request, 1-cycle pass, valid_o=1, RegWrite_o=0, misalign_o=1 for one cycle.
- Byte enables:
  - byte: 1<<off
  - half: 3<<off
  - word: 0xF<<off
  - dword: all ones
- Write data: byte or half value replicated across all lanes.
- Loads:
  - The byte/half/word lane selected by off is extracted from mem_rdata_i.
  - It is sign-extended, or zero-extended when MemUnsigned_i=1.
  - A word load on XLEN=64 is extended the same way.
- Store result: DataMemOut_o=0; RegWrite_o passes through as given.
- Reset mid-BUSY: the request is dropped at once; a later stray ack is ignored.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A cycle counter runs in BUSY.
  - If it reaches TIMEOUT_CYCLES without ack: the request is dropped, the FSM returns to IDLE, and stall_o is released.
  - The registered output is valid_o=1, RegWrite_o=0, bus_err_o=1 for one cycle.
  - The counter clears on entry to BUSY.
- MEM_TIMEOUT_EN undefined:
  - BUSY waits indefinitely for ack.
  - bus_err_o is tied 0.

Test Plan:
- LB at addr 0x103, rdata 0x80FF_1234, ack after 3 cycles → stall_o high 3 cycles, mem_addr_o=0x100, DataMemOut_o=0xFFFF_FF80; repeat as LBU → 0x0000_0080.
- SH at 0x102, data 0x0000_ABCD → mem_be_o=0xC, mem_wdata_o=0xABCD_ABCD, mem_we_o=1 held until ack.
- LW at 0x101 → no mem_req_o, misalign_o=1 one cycle, RegWrite_o=0, stall_o=0.
- Non-memory op followed by LW with same-cycle ack → first result after 1 cycle, LW result after 2 cycles, no dropped or duplicated valid_o.
- rst_i asserted mid-BUSY → mem_req_o=0 immediately; ack one cycle later → no valid_o.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never given → bus_err_o pulse after 4 BUSY cycles, stall_o released.
